// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO family: sticky error flag bundle and
// the helper that sizes occupancy/threshold fields from the entry count.
package fifo_pkg;

   typedef struct packed {
      logic overflow;
      logic underflow;
   } fifo_err_t;

   // Width needed to represent every occupancy value from 0 up to and including depth.
   function automatic int calc_cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/param_fifo_if.sv
// Handshake, data, threshold and status bundle of param_fifo.
// Signal suffixes are named from the FIFO's point of view.
interface param_fifo_if #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_W      = 5
);

   logic                  flush_i;
   logic                  wren_i;
   logic [DATA_WIDTH-1:0] wdata_i;
   logic                  full_o;
   logic                  almost_full_o;
   logic                  rden_i;
   logic [DATA_WIDTH-1:0] rdata_o;
   logic                  empty_o;
   logic                  almost_empty_o;
   logic [CNT_W-1:0]      af_level_i;
   logic [CNT_W-1:0]      ae_level_i;
   logic [CNT_W-1:0]      count_o;
   logic                  overflow_o;
   logic                  underflow_o;
   logic                  err_clr_i;

   // The FIFO itself.
   modport slave (
      input  flush_i, wren_i, wdata_i, rden_i, af_level_i, ae_level_i, err_clr_i,
      output full_o, almost_full_o, rdata_o, empty_o, almost_empty_o,
             count_o, overflow_o, underflow_o
   );

   // Whoever produces into and consumes from the FIFO.
   modport master (
      output flush_i, wren_i, wdata_i, rden_i, af_level_i, ae_level_i, err_clr_i,
      input  full_o, almost_full_o, rdata_o, empty_o, almost_empty_o,
             count_o, overflow_o, underflow_o
   );

endinterface

// File: rtl/fifo_wrap_ptr.sv
// Modulo-DEPTH pointer: advances on inc_i, wraps from DEPTH-1 back to 0,
// and returns to 0 on either reset or the synchronous clear.
module fifo_wrap_ptr #(
   parameter int DEPTH = 16,
   parameter int PTR_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [PTR_W-1:0] ptr_o
);

   localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

   logic [PTR_W-1:0] ptr_q;
   logic [PTR_W-1:0] ptr_d;

   // Clear dominates an increment; the explicit wrap handles non-power-of-two depths.
   always_comb begin
      ptr_d = ptr_q;
      if (clr_i) begin
         ptr_d = '0;
      end else if (inc_i) begin
         ptr_d = (ptr_q == LAST) ? '0 : ptr_q + PTR_W'(1);
      end
   end

   // Pointer register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr_o = ptr_q;

endmodule

// File: rtl/param_fifo.sv
// Parametrised single-clock show-ahead FIFO with programmable almost flags,
// occupancy count, synchronous flush and sticky overflow/underflow flags.
// Every status output is a register loaded from next-state values, so no
// input reaches a flag combinationally.
module param_fifo
   import fifo_pkg::*;
#(
   parameter int DEPTH      = 16,
   parameter int DATA_WIDTH = 32,
   parameter int CNT_W      = calc_cnt_w(DEPTH)
) (
   input logic          clk,
   input logic          rst,
   param_fifo_if.slave  bus
);

   localparam int               PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [PTR_W-1:0] wrPtr;
   logic [PTR_W-1:0] rdPtr;

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic             full_q;
   logic             full_d;
   logic             empty_q;
   logic             empty_d;
   logic             almostFull_q;
   logic             almostFull_d;
   logic             almostEmpty_q;
   logic             almostEmpty_d;
   fifo_err_t        err_q;
   fifo_err_t        err_d;

   logic wrAccept;
   logic rdAccept;
   logic ovSet;
   logic unSet;

   // Accept/reject decisions use only the registered flags; a flush cycle swallows both requests.
   always_comb begin
      wrAccept = bus.wren_i & ~full_q  & ~bus.flush_i;
      rdAccept = bus.rden_i & ~empty_q & ~bus.flush_i;
      ovSet    = bus.wren_i &  full_q  & ~bus.flush_i;
      unSet    = bus.rden_i &  empty_q & ~bus.flush_i;
   end

   // Next occupancy: a simultaneous accepted push and pop cancel out.
   always_comb begin
      count_d = count_q;
      if (bus.flush_i) begin
         count_d = '0;
      end else if (wrAccept && !rdAccept) begin
         count_d = count_q + CNT_W'(1);
      end else if (rdAccept && !wrAccept) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   // Status flags are derived from the next occupancy so they are valid the cycle after the edge.
   always_comb begin
      full_d         = (count_d == DEPTH_C);
      empty_d        = (count_d == '0);
      almostFull_d   = (count_d >= bus.af_level_i);
      almostEmpty_d  = (count_d <= bus.ae_level_i);
      err_d.overflow  = ovSet | (err_q.overflow  & ~bus.err_clr_i);
      err_d.underflow = unSet | (err_q.underflow & ~bus.err_clr_i);
   end

   // Occupancy, flag and sticky-error registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q       <= '0;
         full_q        <= 1'b0;
         empty_q       <= 1'b1;
         almostFull_q  <= 1'b0;
         almostEmpty_q <= 1'b1;
         err_q         <= '0;
      end else begin
         count_q       <= count_d;
         full_q        <= full_d;
         empty_q       <= empty_d;
         almostFull_q  <= almostFull_d;
         almostEmpty_q <= almostEmpty_d;
         err_q         <= err_d;
      end
   end

   // Storage has no reset; only accepted writes touch it.
   always_ff @(posedge clk) begin
      if (!rst && wrAccept) begin
         mem[wrPtr] <= bus.wdata_i;
      end
   end

   fifo_wrap_ptr #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) uWrPtr (
      .clk   (clk),
      .rst   (rst),
      .clr_i (bus.flush_i),
      .inc_i (wrAccept),
      .ptr_o (wrPtr)
   );

   fifo_wrap_ptr #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) uRdPtr (
      .clk   (clk),
      .rst   (rst),
      .clr_i (bus.flush_i),
      .inc_i (rdAccept),
      .ptr_o (rdPtr)
   );

   assign bus.rdata_o        = mem[rdPtr];
   assign bus.count_o        = count_q;
   assign bus.full_o         = full_q;
   assign bus.empty_o        = empty_q;
   assign bus.almost_full_o  = almostFull_q;
   assign bus.almost_empty_o = almostEmpty_q;
   assign bus.overflow_o     = err_q.overflow;
   assign bus.underflow_o    = err_q.underflow;

endmodule
